// File: rtl/operand_issue.sv
// ID->EX issue stage: resolves source operands from forwarding/regfile, detects
// load-use hazards and holds the ID/EX register behind a valid/ready handshake.
module operand_issue #(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   id_valid,
   output logic                   id_ready,
   input  logic [63:0]            id_pc,
   input  logic [4:0]             id_rs1,
   input  logic [4:0]             id_rs2,
   input  logic                   id_use_rs1,
   input  logic                   id_use_rs2,
   input  logic [4:0]             id_rd,
   input  logic                   id_regwrite,
   input  logic                   id_is_load,
   input  logic [63:0]            rf_rdata1,
   input  logic [63:0]            rf_rdata2,
   input  logic [64:0]            fwd_ex1,
   input  logic [64:0]            fwd_mem1,
   input  logic [64:0]            fwd_wb1,
   input  logic [64:0]            fwd_ex2,
   input  logic [64:0]            fwd_mem2,
   input  logic [64:0]            fwd_wb2,
   input  logic                   ex_ready,
   output logic                   ex_valid,
   output logic [63:0]            ex_pc,
   output logic [63:0]            ex_op1,
   output logic [63:0]            ex_op2,
   output logic [4:0]             ex_rd,
   output logic                   ex_regwrite,
   output logic                   ex_is_load,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   // Youngest producer wins; x0 always reads as zero whatever is forwarded.
   function automatic logic [63:0] select_operand(
      input logic [4:0]  rs,
      input logic [64:0] f_ex,
      input logic [64:0] f_mem,
      input logic [64:0] f_wb,
      input logic [63:0] rf
   );
      logic [63:0] v;
      if (f_ex[64])       v = f_ex[63:0];
      else if (f_mem[64]) v = f_mem[63:0];
      else if (f_wb[64])  v = f_wb[63:0];
      else                v = rf;
      if (rs == 5'd0)     v = 64'd0;
      return v;
   endfunction

   function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic                   valid_q, valid_d;
   logic [63:0]            pc_q, pc_d;
   logic [63:0]            op1_q, op1_d;
   logic [63:0]            op2_q, op2_d;
   logic [4:0]             rd_q, rd_d;
   logic                   regwrite_q, regwrite_d;
   logic                   is_load_q, is_load_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

   logic [63:0] op1_res, op2_res;
   logic        load_use, hold;

   assign op1_res = select_operand(id_rs1, fwd_ex1, fwd_mem1, fwd_wb1, rf_rdata1);
   assign op2_res = select_operand(id_rs2, fwd_ex2, fwd_mem2, fwd_wb2, rf_rdata2);

   assign load_use = valid_q & is_load_q & regwrite_q & (rd_q != 5'd0) &
                     ((id_use_rs1 & (id_rs1 == rd_q)) | (id_use_rs2 & (id_rs2 == rd_q)));
   assign hold     = valid_q & ~ex_ready;
   assign id_ready = ~load_use & ~hold;

   always_comb begin
      valid_d    = valid_q;
      pc_d       = pc_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      rd_d       = rd_q;
      regwrite_d = regwrite_q;
      is_load_d  = is_load_q;
      cnt_d      = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (hold) begin
         valid_d = valid_q;
      end else if (id_valid && id_ready) begin
         valid_d    = 1'b1;
         pc_d       = id_pc;
         op1_d      = op1_res;
         op2_d      = op2_res;
         rd_d       = id_rd;
         regwrite_d = id_regwrite;
         is_load_d  = id_is_load;
      end else if (id_valid && load_use) begin
         valid_d = 1'b0;
         cnt_d   = sat_inc(cnt_q);
      end else begin
         valid_d = 1'b0;
      end
   end

   // ID/EX register boundary
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= 1'b0;
         pc_q       <= 64'd0;
         op1_q      <= 64'd0;
         op2_q      <= 64'd0;
         rd_q       <= 5'd0;
         regwrite_q <= 1'b0;
         is_load_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         op1_q      <= op1_d;
         op2_q      <= op2_d;
         rd_q       <= rd_d;
         regwrite_q <= regwrite_d;
         is_load_q  <= is_load_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = pc_q;
   assign ex_op1      = op1_q;
   assign ex_op2      = op2_q;
   assign ex_rd       = rd_q;
   assign ex_regwrite = regwrite_q;
   assign ex_is_load  = is_load_q;
   assign stall_cnt   = cnt_q;

endmodule

// File: doc/operand_issue.md
Name: operand_issue

Overview:
- ID→EX issue stage, directly downstream of the per-operand forwarding units.
- Merges register-file read data with forwarded values from EX, MEM and WB, using a fixed priority.
- Detects load-use hazards and inserts a one-cycle bubble when one occurs.
- Holds the ID/EX pipeline register and exchanges a valid/ready handshake with both neighbouring stages.

Parameters:
- STALL_CNT_W, 32: width of the saturating load-use stall counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  squash the ID/EX register (branch/exception redirect)
- id_valid  in  1  decode holds an instruction
- id_ready  out  1  this stage accepts the decode instruction this cycle
- id_pc  in  64  instruction PC (word_t)
- id_rs1, id_rs2  in  5  source registers (creg_addr_t)
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  5  destination register
- id_regwrite  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- rf_rdata1, rf_rdata2  in  64  register-file read data
- fwd_ex1, fwd_mem1, fwd_wb1  in  65  fwd_data_t {enable, data} for rs1
- fwd_ex2, fwd_mem2, fwd_wb2  in  65  fwd_data_t {enable, data} for rs2
- ex_ready  in  1  EX stage accepts the registered instruction
- ex_valid  out  1  ID/EX register holds a valid instruction
- ex_pc  out  64  registered PC
- ex_op1, ex_op2  out  64  registered resolved operands
- ex_rd  out  5  registered rd
- ex_regwrite  out  1  registered regwrite
- ex_is_load  out  1  registered is_load
- stall_cnt  out  STALL_CNT_W  count of load-use bubble cycles

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - ex_valid=0; ex_pc, ex_op1, ex_op2, ex_rd = 0; ex_regwrite=0; ex_is_load=0; stall_cnt=0.
  - Reset overrides flush and all other inputs.
- Operand select (combinational), shown for op1; op2 is identical using the *2 inputs:
  - fwd_ex1.enable → fwd_ex1.data
  - else fwd_mem1.enable → fwd_mem1.data
  - else fwd_wb1.enable → fwd_wb1.data
  - else rf_rdata1
  - If id_rs1==0, op1=0 regardless of any enables.
- load_use (combinational):
  - Asserted when ex_valid & ex_is_load & ex_regwrite & ex_rd!=0 and either (id_use_rs1 & id_rs1==ex_rd) or (id_use_rs2 & id_rs2==ex_rd).
- hold = ex_valid & !ex_ready.
- id_ready = !load_use & !hold. It does not depend on flush.
- Register update each clk edge, in priority order:
  1. reset → reset values.
  2. flush → ex_valid=0; payload don't-care; stall_cnt unchanged.
  3. hold → all ex_* outputs keep their values.
  4. id_valid & id_ready → capture id_pc, the resolved op1/op2, id_rd, id_regwrite, id_is_load; ex_valid=1.
  5. id_valid & load_use → ex_valid=0 (bubble); stall_cnt += 1, saturating at all-ones.
  6. otherwise → ex_valid=0.
- Latency: one cycle from decode handshake to ex_valid.
- Throughput: one instruction per cycle when there is no hazard or backpressure.
- Load-use costs exactly one bubble cycle:
  - Next cycle the load has left ID/EX, so load_use deasserts.
  - The value then arrives via fwd_mem*.
- Simultaneous load_use and hold: hold wins; no bubble is inserted and stall_cnt is not incremented.
- Operands are sampled only on capture. Forwarding inputs are ignored while held or stalled.
- An ex_rd=0 load never triggers load_use.
- A flush during a load-use stall drops the bubble; the decode instruction is not captured that cycle.

Test Plan:
- Forward priority:
  - Stimulus: id_rs1=5, id_use_rs1=1, rf_rdata1=0x11, fwd_wb1={1,0x33}, fwd_mem1={1,0x22}, fwd_ex1={1,0x44}.
  - Required: ex_op1=0x44 next cycle. With fwd_ex1.enable dropped, ex_op1=0x22.
- x0 guard:
  - Stimulus: id_rs2=0, fwd_ex2={1,0xDEAD}, rf_rdata2=0x7.
  - Required: ex_op2=0.
- Load-use bubble:
  - Stimulus: issue a load with rd=3, then id_rs1=3, id_use_rs1=1.
  - Required: id_ready=0 for one cycle, ex_valid=0 that cycle, stall_cnt=1. Next cycle, with fwd_mem1={1,0x99}, ex_op1=0x99 and ex_valid=1.
- Backpressure:
  - Stimulus: ex_ready=0 for 3 cycles with ex_pc=0x80000010.
  - Required: ex_* stable, id_ready=0, stall_cnt unchanged.
- Flush vs capture:
  - Stimulus: flush=1 with id_valid=1.
  - Required: ex_valid=0 next cycle.
- Saturation and reset:
  - Stimulus: set STALL_CNT_W=2 and force 5 load-use stalls.
  - Required: stall_cnt=3. Asserting reset mid-hold gives ex_valid=0 and stall_cnt=0 on the next edge.
